if_fetch_ctrl: RTL

- Sequencing controller for the instruction-fetch stage; drives the IF stage's freeze and Branch_Taken/Branch_Address inputs and the IF/ID and ID/EX pipeline-register control.
- Arbitrates between four events: post-reset boot hold, instruction-memory wait states, load-use hazard stalls from the hazard unit, and MEM-stage stalls, with branch redirects from EXE layered on top.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/if_fetch_ctrl_if.sv | 34 +++
 rtl/if_fetch_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Bundle between the IF-stage sequencing controller and its pipeline neighbours.
// slave = controller side, master = hazard unit / EXE / IF stage side.
interface if_fetch_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              hazard_detected;
  logic              mem_stall;
  logic              branch_taken_in;
  logic [ADDR_W-1:0] branch_addr_in;
  logic              stat_clear;

  logic              freeze_pc;
  logic              branch_taken_out;
  logic [ADDR_W-1:0] branch_addr_out;
  logic              freeze_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              fetch_valid;
  logic [CNT_W-1:0]  stall_count;
  logic [1:0]        ctrl_state;

  modport slave (
    input  hazard_detected, mem_stall, branch_taken_in, branch_addr_in, stat_clear,
    output freeze_pc, branch_taken_out, branch_addr_out, freeze_if_id,
           flush_if_id, flush_id_ex, fetch_valid, stall_count, ctrl_state
  );

  modport master (
    output hazard_detected, mem_stall, branch_taken_in, branch_addr_in, stat_clear,
    input  freeze_pc, branch_taken_out, branch_addr_out, freeze_if_id,
           flush_if_id, flush_id_ex, fetch_valid, stall_count, ctrl_state
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller: boot hold, imem wait states, load-use
// and MEM stalls, EXE branch redirects, plus a saturating stall-cycle counter.
module if_fetch_ctrl #(
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned IMEM_WAIT  = 0
) (
  input logic           clk,
  input logic           rst,
  if_fetch_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_IWAIT = 2'd2;

  localparam logic [3:0]       BOOT_LAST  = 4'(RESET_HOLD - 1);
  localparam logic [2:0]       WAIT_LOAD  = 3'(IMEM_WAIT);
  localparam logic [1:0]       FETCH_NEXT = (IMEM_WAIT == 0) ? S_RUN : S_IWAIT;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state, state_nx;
  logic [3:0]       boot_cnt, boot_nx;
  logic [2:0]       wait_cnt, wait_nx;
  logic [CNT_W-1:0] stall_cnt;

  logic fz_pc, br_out, fz_ifid, fl_ifid, fl_idex, f_valid, stall_inc;

  // State and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      boot_cnt <= boot_nx;
      wait_cnt <= wait_nx;
      if (bus.stat_clear)
        stall_cnt <= '0;
      else if (stall_inc && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and event arbitration: mem_stall > branch > hazard > memory wait
  always_comb begin
    state_nx = state;
    boot_nx  = boot_cnt;
    wait_nx  = wait_cnt;
    fz_pc    = 1'b0;
    br_out   = 1'b0;
    fz_ifid  = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    f_valid  = 1'b0;

    case (state)
      S_BOOT: begin
        fz_pc   = 1'b1;
        fl_ifid = 1'b1;
        boot_nx = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) begin
          state_nx = FETCH_NEXT;
          wait_nx  = WAIT_LOAD;
        end
      end
      S_RUN, S_IWAIT: begin
        if (bus.mem_stall) begin
          fz_pc   = 1'b1;
          fz_ifid = 1'b1;
        end else if (bus.branch_taken_in) begin
          br_out   = 1'b1;
          fl_ifid  = 1'b1;
          fl_idex  = 1'b1;
          state_nx = FETCH_NEXT;
          wait_nx  = WAIT_LOAD;
        end else if (bus.hazard_detected) begin
          fz_pc   = 1'b1;
          fz_ifid = 1'b1;
          fl_idex = 1'b1;
        end else if (state == S_RUN) begin
          f_valid  = 1'b1;
          state_nx = FETCH_NEXT;
          wait_nx  = WAIT_LOAD;
        end else begin
          fz_pc   = 1'b1;
          wait_nx = wait_cnt - 3'd1;
          if (wait_cnt == 3'd1)
            state_nx = S_RUN;
        end
      end
      default: begin
        fz_pc    = 1'b1;
        fl_ifid  = 1'b1;
        state_nx = S_BOOT;
      end
    endcase

    stall_inc = ((state == S_RUN) || (state == S_IWAIT)) && fz_pc;
  end

  assign bus.freeze_pc        = fz_pc;
  assign bus.branch_taken_out = br_out;
  assign bus.branch_addr_out  = bus.branch_addr_in;
  assign bus.freeze_if_id     = fz_ifid;
  assign bus.flush_if_id      = fl_ifid;
  assign bus.flush_id_ex      = fl_idex;
  assign bus.fetch_valid      = f_valid;
  assign bus.stall_count      = stall_cnt;
  assign bus.ctrl_state       = state;
endmodule
